// File: rtl/mole_scheduler.sv
// -----------------------------------------------------------------------------
// mole_scheduler
// Game-level controller for the whack-a-mole sprite datapath. Runs one
// lifecycle FSM per hole (EMPTY -> UP -> HIT/EMPTY), spawns moles at
// LFSR-chosen holes on a fixed tick gap, times mole exposure, resolves whack
// strobes and drives the per-hole 2-bit shape code for the sprite ROM.
//
// Ports
//   clk          system clock
//   Reset        synchronous, active-high reset
//   tick         1 ms strobe, one clk wide
//   enable       game running; low freezes states, timers and whacks
//   whack_valid  one-cycle whack strobe
//   whack_hole   whack hole index; bits above log2(NUM_HOLES) ignored
//   hole_shape   hole i at [2i+1:2i]: 00 EMPTY, 01 UP, 10 HIT
//   score_pulse  one-cycle pulse on a whack of an UP hole
//   miss_pulse   one-cycle pulse on a whack of an EMPTY or HIT hole
//   escape_pulse one-cycle pulse when any UP mole times out
//   active_cnt   number of holes currently UP
//
// Hole states
//   state | meaning
//   EMPTY | no mole; eligible for spawn
//   UP    | mole exposed; whack scores, timer expiry escapes
//   HIT   | mole was whacked; shows hit sprite until timer expiry
// -----------------------------------------------------------------------------
module mole_scheduler #(
    parameter int         NUM_HOLES    = 4,
    parameter int         UP_TIME_MS   = 1000,
    parameter int         HIT_TIME_MS  = 250,
    parameter int         SPAWN_GAP_MS = 500,
    parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
    input  logic                   clk,
    input  logic                   Reset,
    input  logic                   tick,
    input  logic                   enable,
    input  logic                   whack_valid,
    input  logic [2:0]             whack_hole,
    output logic [2*NUM_HOLES-1:0] hole_shape,
    output logic                   score_pulse,
    output logic                   miss_pulse,
    output logic                   escape_pulse,
    output logic [3:0]             active_cnt
);
    localparam int          IDX_W    = $clog2(NUM_HOLES);
    localparam logic [15:0] UP_LOAD  = 16'(UP_TIME_MS);
    localparam logic [15:0] HIT_LOAD = 16'(HIT_TIME_MS);
    localparam logic [15:0] GAP_LOAD = 16'(SPAWN_GAP_MS);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        UP    = 2'b01,
        HIT   = 2'b10
    } hole_state_t;

    hole_state_t      state     [NUM_HOLES];
    hole_state_t      state_nxt [NUM_HOLES];
    logic [15:0]      timer     [NUM_HOLES];
    logic [15:0]      timer_nxt [NUM_HOLES];
    logic [15:0]      spawn_cnt;
    logic [15:0]      spawn_cnt_nxt;
    logic [7:0]       lfsr;
    logic             score_nxt;
    logic             miss_nxt;
    logic             escape_nxt;
    logic [3:0]       active_nxt;
    logic             advance;
    logic             whack_go;
    logic             spawn_fire;
    logic             spawn_found;
    logic             spawn_go;
    logic [IDX_W-1:0] whack_idx;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] spawn_sel;

    assign advance    = tick & enable;
    assign whack_go   = whack_valid & enable;
    assign whack_idx  = whack_hole[IDX_W-1:0];
    assign cand       = lfsr[IDX_W-1:0];
    assign spawn_fire = advance && (spawn_cnt == 16'd1);
    assign spawn_go   = spawn_fire && spawn_found;

    generate
        if (IDX_W < 3) begin : g_unused_hole_bits
            logic unused_hole_bits;
            assign unused_hole_bits = ^whack_hole[2:IDX_W];
        end
    endgenerate

    // Wrap-around scan from the LFSR candidate; index width makes the mod free.
    always_comb begin
        spawn_found = 1'b0;
        spawn_sel   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_HOLES; k++) begin
            scan_idx = cand + IDX_W'(k);
            if (!spawn_found && state[scan_idx] == EMPTY) begin
                spawn_found = 1'b1;
                spawn_sel   = scan_idx;
            end
        end
    end

    always_comb begin
        spawn_cnt_nxt = spawn_cnt;
        if (advance) begin
            spawn_cnt_nxt = spawn_fire ? GAP_LOAD : spawn_cnt - 16'd1;
        end
    end

    always_comb begin
        score_nxt  = 1'b0;
        miss_nxt   = 1'b0;
        escape_nxt = 1'b0;
        active_nxt = '0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            state_nxt[i] = state[i];
            timer_nxt[i] = timer[i];
            case (state[i])
                EMPTY: begin
                    if (whack_go && whack_idx == IDX_W'(i)) miss_nxt = 1'b1;
                    if (spawn_go && spawn_sel == IDX_W'(i)) begin
                        state_nxt[i] = UP;
                        timer_nxt[i] = UP_LOAD;
                    end
                end
                UP: begin
                    // A whack on the expiry tick still lands as a hit.
                    if (whack_go && whack_idx == IDX_W'(i)) begin
                        state_nxt[i] = HIT;
                        timer_nxt[i] = HIT_LOAD;
                        score_nxt    = 1'b1;
                    end else if (advance) begin
                        if (timer[i] == 16'd1) begin
                            state_nxt[i] = EMPTY;
                            timer_nxt[i] = '0;
                            escape_nxt   = 1'b1;
                        end else begin
                            timer_nxt[i] = timer[i] - 16'd1;
                        end
                    end
                end
                HIT: begin
                    if (whack_go && whack_idx == IDX_W'(i)) miss_nxt = 1'b1;
                    if (advance) begin
                        if (timer[i] == 16'd1) begin
                            state_nxt[i] = EMPTY;
                            timer_nxt[i] = '0;
                        end else begin
                            timer_nxt[i] = timer[i] - 16'd1;
                        end
                    end
                end
                default: begin
                    state_nxt[i] = EMPTY;
                    timer_nxt[i] = '0;
                end
            endcase
            if (state_nxt[i] == UP) active_nxt = active_nxt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_HOLES; i++) begin
                state[i] <= EMPTY;
                timer[i] <= '0;
            end
            spawn_cnt    <= GAP_LOAD;
            lfsr         <= LFSR_SEED;
            score_pulse  <= 1'b0;
            miss_pulse   <= 1'b0;
            escape_pulse <= 1'b0;
            active_cnt   <= '0;
        end else begin
            for (int i = 0; i < NUM_HOLES; i++) begin
                state[i] <= state_nxt[i];
                timer[i] <= timer_nxt[i];
            end
            spawn_cnt    <= spawn_cnt_nxt;
            lfsr         <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            score_pulse  <= score_nxt;
            miss_pulse   <= miss_nxt;
            escape_pulse <= escape_nxt;
            active_cnt   <= active_nxt;
        end
    end

    always_comb begin
        hole_shape = '0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            hole_shape[2*i +: 2] = state[i];
        end
    end

endmodule

// File: tb/tb_mole_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mole_scheduler
// Two scheduler instances share one stimulus stream: dut0 uses a short UP time
// (4 ticks) so escapes and races happen often, dut1 uses UP=100 so the board
// can fill completely. A tick-level reference model of the game rules predicts
// every output of both instances each cycle; a few directed checks with
// hand-derived values pin the model itself.
// -----------------------------------------------------------------------------
module tb_mole_scheduler;
    localparam int N    = 4;
    localparam int UPT0 = 4;
    localparam int UPT1 = 100;
    localparam int HITT = 2;
    localparam int GAP  = 3;

    logic       clk = 1'b0;
    logic       Reset;
    logic       tick;
    logic       enable;
    logic       whack_valid;
    logic [2:0] whack_hole;
    logic [7:0] shape0, shape1;
    logic       sc0, sc1, mi0, mi1, es0, es1;
    logic [3:0] ac0, ac1;

    mole_scheduler #(.NUM_HOLES(N), .UP_TIME_MS(UPT0), .HIT_TIME_MS(HITT),
                     .SPAWN_GAP_MS(GAP), .LFSR_SEED(8'hA5)) dut0 (
        .clk(clk), .Reset(Reset), .tick(tick), .enable(enable),
        .whack_valid(whack_valid), .whack_hole(whack_hole), .hole_shape(shape0),
        .score_pulse(sc0), .miss_pulse(mi0), .escape_pulse(es0), .active_cnt(ac0));

    mole_scheduler #(.NUM_HOLES(N), .UP_TIME_MS(UPT1), .HIT_TIME_MS(HITT),
                     .SPAWN_GAP_MS(GAP), .LFSR_SEED(8'hA5)) dut1 (
        .clk(clk), .Reset(Reset), .tick(tick), .enable(enable),
        .whack_valid(whack_valid), .whack_hole(whack_hole), .hole_shape(shape1),
        .score_pulse(sc1), .miss_pulse(mi1), .escape_pulse(es1), .active_cnt(ac1));

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit checking    = 1'b0;

    // Reference model: hole kind (0 empty, 1 up, 2 hit) and ticks remaining.
    int         m_st    [2][N];
    int         m_rem   [2][N];
    int         m_spawn [2];
    logic [7:0] m_lfsr;
    logic [7:0] e_shape  [2];
    logic       e_score  [2];
    logic       e_miss   [2];
    logic       e_escape [2];
    logic [3:0] e_active [2];

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int d, input int upt);
        int         ns [N];
        int         nr [N];
        int         sel, wi, c;
        bit         adv, whk, sc, mi, es;
        logic [7:0] sh;
        logic [3:0] ac;
        adv = tick && enable;
        whk = whack_valid && enable;
        wi  = whack_hole % N;
        sc = 0; mi = 0; es = 0; sel = -1;
        if (adv) begin
            m_spawn[d]--;
            if (m_spawn[d] == 0) begin
                m_spawn[d] = GAP;
                c = m_lfsr % N;
                for (int k = 0; k < N; k++)
                    if (sel < 0 && m_st[d][(c + k) % N] == 0) sel = (c + k) % N;
            end
        end
        for (int h = 0; h < N; h++) begin
            ns[h] = m_st[d][h];
            nr[h] = m_rem[d][h];
            if (whk && wi == h && m_st[d][h] == 1) begin
                ns[h] = 2; nr[h] = HITT; sc = 1;
            end else begin
                if (whk && wi == h) mi = 1;
                if (adv && m_st[d][h] != 0) begin
                    nr[h]--;
                    if (nr[h] == 0) begin
                        if (m_st[d][h] == 1) es = 1;
                        ns[h] = 0;
                    end
                end
            end
            if (h == sel) begin ns[h] = 1; nr[h] = upt; end
        end
        sh = '0; ac = '0;
        for (int h = 0; h < N; h++) begin
            m_st[d][h]  = ns[h];
            m_rem[d][h] = nr[h];
            sh[2*h +: 2] = 2'(ns[h]);
            if (ns[h] == 1) ac++;
        end
        e_shape[d] = sh; e_active[d] = ac;
        e_score[d] = sc; e_miss[d] = mi; e_escape[d] = es;
    endtask

    always @(posedge clk) begin
        if (Reset) begin
            for (int d = 0; d < 2; d++) begin
                for (int h = 0; h < N; h++) begin m_st[d][h] = 0; m_rem[d][h] = 0; end
                m_spawn[d] = GAP;
                e_shape[d] = '0; e_active[d] = '0;
                e_score[d] = 1'b0; e_miss[d] = 1'b0; e_escape[d] = 1'b0;
            end
            m_lfsr = 8'hA5;
        end else begin
            model_step(0, UPT0);
            model_step(1, UPT1);
            m_lfsr = lfsr_next(m_lfsr);
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("shape0",  16'(shape0), 16'(e_shape[0]));
            check("score0",  16'(sc0),    16'(e_score[0]));
            check("miss0",   16'(mi0),    16'(e_miss[0]));
            check("escape0", 16'(es0),    16'(e_escape[0]));
            check("active0", 16'(ac0),    16'(e_active[0]));
            check("shape1",  16'(shape1), 16'(e_shape[1]));
            check("score1",  16'(sc1),    16'(e_score[1]));
            check("miss1",   16'(mi1),    16'(e_miss[1]));
            check("escape1", 16'(es1),    16'(e_escape[1]));
            check("active1", 16'(ac1),    16'(e_active[1]));
        end
    end

    task automatic drive(input bit r, input bit t, input bit e, input bit wv, input logic [2:0] wh);
        Reset = r; tick = t; enable = e; whack_valid = wv; whack_hole = wh;
        @(negedge clk);
    endtask

    initial begin
        // Reset
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        checking = 1'b1;
        check("rst_shape0",  16'(shape0), 16'h0);
        check("rst_shape1",  16'(shape1), 16'h0);
        check("rst_pulses",  16'({sc0, mi0, es0, sc1, mi1, es1}), 16'h0);
        check("rst_active0", 16'(ac0), 16'h0);

        // Spawn: LFSR A5,4A,95 -> third tick edge picks hole 95&3 = 1
        drive(0, 1, 1, 0, 0);
        drive(0, 1, 1, 0, 0);
        check("pre_spawn", 16'(shape0), 16'h00);
        drive(0, 1, 1, 0, 0);
        check("spawn_shape",  16'(shape0), 16'h04);
        check("spawn_active", 16'(ac0),    16'h1);

        // Second spawn: LFSR A9 -> candidate 1 busy, hole 2 taken
        repeat (3) drive(0, 1, 1, 0, 0);
        check("spawn2_shape",  16'(shape0), 16'h14);
        check("spawn2_active", 16'(ac0),    16'h2);

        // Escape of hole 1 after its 4th tick
        drive(0, 1, 1, 0, 0);
        check("escape_shape",  16'(shape0), 16'h10);
        check("escape_pulse",  16'(es0),    16'h1);
        check("escape_active", 16'(ac0),    16'h1);
        drive(0, 0, 1, 0, 0);
        check("escape_once", 16'(es0), 16'h0);

        // Hit hole 2, then HIT clears after 2 ticks with a spawn at hole 3 (LFSR 3B)
        drive(0, 0, 1, 1, 3'd2);
        check("hit_shape",  16'(shape0), 16'h20);
        check("hit_score",  16'(sc0),    16'h1);
        check("hit_miss",   16'(mi0),    16'h0);
        check("hit_active", 16'(ac0),    16'h0);
        drive(0, 1, 1, 0, 0);
        check("hit_hold", 16'(shape0), 16'h20);
        drive(0, 1, 1, 0, 0);
        check("hit_clear",  16'(shape0), 16'h40);
        check("hit_no_esc", 16'(es0),    16'h0);
        check("hit_active2", 16'(ac0),   16'h1);

        // Miss on an EMPTY hole
        drive(0, 0, 1, 1, 3'd0);
        check("miss_pulse", 16'(mi0),    16'h1);
        check("miss_score", 16'(sc0),    16'h0);
        check("miss_shape", 16'(shape0), 16'h40);

        // Whack on the expiry tick of hole 3 (index 7 aliases to 3)
        repeat (3) drive(0, 1, 1, 0, 0);
        drive(0, 1, 1, 1, 3'd7);
        check("race_shape",  16'(shape0[7:6]), 16'h2);
        check("race_score",  16'(sc0),         16'h1);
        check("race_no_esc", 16'(es0),         16'h0);

        // Randomized play
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
                  3'($urandom_range(0, 7)));
        end

        // Full board and freeze on the UP=100 instance
        drive(1, 0, 0, 0, 0);
        repeat (12) drive(0, 1, 1, 0, 0);
        check("full_shape",  16'(shape1), 16'h55);
        check("full_active", 16'(ac1),    16'h4);
        repeat (3) drive(0, 1, 1, 0, 0);
        check("full_skip", 16'(shape1), 16'h55);
        for (int i = 0; i < 50; i++) begin
            drive(0, 1, 0, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)));
            check("frz_pulses", 16'({sc0, mi0, es0, sc1, mi1, es1}), 16'h0);
        end
        check("frz_shape",  16'(shape1), 16'h55);
        check("frz_active", 16'(ac1),    16'h4);

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
